aes_key_expansion: RTL and testbench
====================================

# aes_key_expansion

AES-128 key schedule stage feeding the encryption datapath. On `init`, expands a 128-bit cipher key into 11 round keys (rounds 0..10), one round key per cycle. Keys are held in an internal store and served by round index. SubWord uses a shared external 32-bit S-box port; the top level muxes that port to this block while `ready` is low.

## Interface
- `ROUNDS`, 10: number of expansion rounds; slots = ROUNDS+1.
- `clk` in 1: clock; all state on rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `init` in 1: start-expansion pulse; honoured only when `ready`=1.
- `key` in 128: cipher key; sampled on the edge where `init` is accepted.
- `round` in 4: round-key select from the encryption block.
- `roundKey` out 128: `store[round]`, combinational; 0 when `round`>ROUNDS.
- `beforeSub` out 32: word sent to the shared S-box; 0 when idle.
- `afterSub` in 32: S-box result for `beforeSub`, combinational, same cycle.
- `ready` out 1: 1 = idle and able to accept `init`.
- `keyValid` out 1: 1 = store holds a complete schedule for the last accepted key.

## Operation
- FSM states: IDLE, GEN.
- IDLE with `init`=1:
  - slot0 <= `key`; work <= `key`; rcon <= 8'h01; roundCtr <= 1.
  - `ready` <= 0; `keyValid` <= 0; go to GEN.
- GEN, each cycle:
  - `beforeSub` = work[31:0] (w3).
  - t = {afterSub[23:0], afterSub[31:24]} ^ {rcon, 24'h0}, i.e. RotWord after SubWord.
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
  - work <= {n0,n1,n2,n3}; store[roundCtr] <= same.
  - rcon <= xtime(rcon), i.e. {rcon[6:0],0} ^ (8'h1b & {8{rcon[7]}}).
  - roundCtr <= roundCtr+1.
- Completion: the GEN cycle with roundCtr==ROUNDS writes slot 10, sets `ready` <= 1 and `keyValid` <= 1, and returns to IDLE.
- Width rules: roundCtr is 4 bits; rcon is 8 bits and reaches 8'h36 on round 10; all XORs are 32-bit with no carries.
- Boundary conditions:
  - `init` during GEN is ignored; the current expansion completes unchanged.
  - `init` held high over consecutive IDLE cycles restarts at each accepted edge, so only one restart occurs per completion.
  - `round` may change any cycle. Reads during GEN return partially updated store contents; consumers gate on `keyValid`.
  - Reset mid-GEN aborts the expansion; the store is zeroed.

## Timing
- Reset values:
  - `ready`=1, `keyValid`=0, state IDLE.
  - roundCtr=0, rcon=8'h01, work and all store slots = 0.
  - `roundKey`=0, `beforeSub`=0.
- `init` accepted at edge E0.
  - `ready`/`keyValid` low after E0.
  - Slot k is written at edge Ek (k=1..10).
  - `ready` and `keyValid` are high after E10, so `ready` is low for exactly 10 cycles.
- Next `init` can be accepted at E11 at the earliest.
- `roundKey` has zero-cycle latency from `round`.
- The S-box loop is fully combinational within one cycle, so `afterSub` must settle in the same cycle.

## Structure
- Shared AES package holds:
  - constants ROUNDS=4'ha, NK=4, RCON_INIT=8'h01;
  - the xtime function, shared with the MixColumns multiply-by-02 in the encryption block;
  - the 128-bit block/word typedefs.
- No sub-module is required. The S-box is external and shared, and the store is an 11x128 register array inside this block.

## Test plan
- Reset then idle: `ready`=1, `keyValid`=0, `roundKey`=0 for `round`=0..15, `beforeSub`=0.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, `init` one cycle:
  - `ready` is low 10 cycles, then `keyValid`=1.
  - `round`=0 gives the key.
  - `round`=1 gives a0fafe1788542cb123a339392a6c7605.
  - `round`=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `round`=11 gives 0.
- All-zero key: `round`=1 gives 62636363626363636263636362636363; `round`=10 gives b4ef5bcb3e92e21123e951cf6f8f188e.
- `init` with a different key re-pulsed at cycles 3 and 7 of a running expansion: ignored; final schedule matches the first key; completion is still at E10.
- Reset asserted at cycle 5 of GEN: next cycle `ready`=1, `keyValid`=0, all slots read 0; a new `init` then completes normally.
- `init` held high continuously: successive expansions start every 11 cycles, and `keyValid` pulses high for one cycle between them.

Source files
------------

// File: rtl/aes_key_expansion_pkg.sv
// Shared AES definitions: round count, key-schedule constants, GF(2^8) xtime,
// and the block/word types used by the key schedule and the cipher datapath.
package aes_key_expansion_pkg;

    localparam logic [3:0] ROUNDS    = 4'ha;
    localparam int unsigned NK       = 4;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef logic [127:0] block_t;
    typedef logic [31:0]  word_t;

    typedef enum logic {
        IDLE,
        GEN
    } ks_state_t;

    // Multiply by x (02) in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

endpackage

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule: expands the cipher key into ROUNDS+1 round keys,
// one per cycle, using a shared external S-box, and serves them by index.
module aes_key_expansion
    import aes_key_expansion_pkg::*;
#(
    parameter int unsigned ROUNDS = 32'(aes_key_expansion_pkg::ROUNDS)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         init,
    input  logic [127:0] key,
    input  logic [3:0]   round,
    output logic [127:0] roundKey,
    output logic [31:0]  beforeSub,
    input  logic [31:0]  afterSub,
    output logic         ready,
    output logic         keyValid
);

    localparam logic [3:0] LAST = 4'(ROUNDS);

    ks_state_t  state;
    block_t     store [ROUNDS+1];
    block_t     work;
    logic [7:0] rcon;
    logic [3:0] roundCtr;

    word_t      t;
    word_t      acc;
    block_t     nextWork;

    // Next round key: RotWord(SubWord(w3)) ^ rcon, then the chained word XORs
    always_comb begin
        beforeSub = (state == GEN) ? work[31:0] : '0;
        t         = {afterSub[23:0], afterSub[31:24]} ^ {rcon, 24'h0};
        acc       = t;
        nextWork  = '0;
        for (int unsigned i = 0; i < NK; i++) begin
            acc = acc ^ work[127 - 32*i -: 32];
            nextWork[127 - 32*i -: 32] = acc;
        end
    end

    // Round-key read port, zero for indices beyond the last round
    always_comb begin
        roundKey = '0;
        if (32'(round) <= ROUNDS) begin
            roundKey = store[round];
        end
    end

    // Expansion FSM: accept init in IDLE, generate one round key per GEN cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ready    <= 1'b1;
            keyValid <= 1'b0;
            roundCtr <= '0;
            rcon     <= RCON_INIT;
            work     <= '0;
            for (int unsigned i = 0; i <= ROUNDS; i++) begin
                store[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (init) begin
                        store[0] <= key;
                        work     <= key;
                        rcon     <= RCON_INIT;
                        roundCtr <= 4'd1;
                        ready    <= 1'b0;
                        keyValid <= 1'b0;
                        state    <= GEN;
                    end
                end
                GEN: begin
                    work            <= nextWork;
                    store[roundCtr] <= nextWork;
                    rcon            <= xtime(rcon);
                    roundCtr        <= roundCtr + 4'd1;
                    if (roundCtr == LAST) begin
                        ready    <= 1'b1;
                        keyValid <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion: models the shared S-box and the
// FIPS-197 key schedule at word level and compares against the DUT.
module tb_aes_key_expansion;

    logic         clk;
    logic         reset;
    logic         init;
    logic [127:0] key;
    logic [3:0]   round;
    logic [127:0] roundKey;
    logic [31:0]  beforeSub;
    logic [31:0]  afterSub;
    logic         ready;
    logic         keyValid;

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox [256];
    logic [127:0] exp_rk [11];

    aes_key_expansion #(.ROUNDS(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .init     (init),
        .key      (key),
        .round    (round),
        .roundKey (roundKey),
        .beforeSub(beforeSub),
        .afterSub (afterSub),
        .ready    (ready),
        .keyValid (keyValid)
    );

    // Shared S-box, combinational
    assign afterSub = {sbox[beforeSub[31:24]], sbox[beforeSub[23:16]],
                       sbox[beforeSub[15:8]],  sbox[beforeSub[7:0]]};

    initial clk = 1'b0;
    always #50 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // Textbook word-oriented key expansion, 44 words
    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_schedule(input string tag);
        for (int r = 0; r < 16; r++) begin
            round = 4'(r);
            #1;
            check($sformatf("%s_rk%0d", tag, r), roundKey, (r <= 10) ? exp_rk[r] : 128'h0);
        end
    endtask

    task automatic read_round(input logic [3:0] r, input string tag, input logic [127:0] expv);
        round = r;
        #1;
        check(tag, roundKey, expv);
    endtask

    // Accept init with key k, optionally pulse init with key 'other' at cycles p1/p2,
    // optionally leave init held high; check latency, S-box words and the schedule.
    task automatic start_and_wait(input logic [127:0] k, input logic [127:0] other,
                                  input int p1, input int p2, input bit hold, input string tag);
        int cyc;
        expand(k);
        key  = k;
        init = 1'b1;
        step();
        if (!hold) init = 1'b0;
        check({tag, "_ready_low"}, ready, 0);
        check({tag, "_kv_low"}, keyValid, 0);
        cyc = 0;
        while (!ready && cyc < 20) begin
            if (cyc <= 10)
                check($sformatf("%s_bsub%0d", tag, cyc), beforeSub, exp_rk[cyc][31:0]);
            if (cyc == p1 || cyc == p2) begin
                key  = other;
                init = 1'b1;
            end
            step();
            if (!hold) begin
                init = 1'b0;
                key  = k;
            end
            cyc++;
        end
        check({tag, "_cycles"}, cyc, 10);
        check({tag, "_ready_done"}, ready, 1);
        check({tag, "_kv_done"}, keyValid, 1);
        check_schedule(tag);
    endtask

    initial begin
        logic [127:0] k;
        logic [127:0] k2;

        reset = 1'b1;
        init  = 1'b0;
        key   = '0;
        round = '0;
        build_sbox();
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_ready", ready, 1);
        check("rst_kv", keyValid, 0);
        check("rst_bsub", beforeSub, 0);
        for (int r = 0; r < 11; r++) exp_rk[r] = '0;
        check_schedule("rst");

        // FIPS-197 vector
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        start_and_wait(k, '0, -1, -1, 1'b0, "fips");
        read_round(4'd0, "fips_r0", k);
        read_round(4'd1, "fips_r1", 128'ha0fafe1788542cb123a339392a6c7605);
        read_round(4'd10, "fips_r10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_round(4'd11, "fips_r11", 128'h0);

        // All-zero key
        start_and_wait('0, '0, -1, -1, 1'b0, "zero");
        read_round(4'd1, "zero_r1", 128'h62636363626363636263636362636363);
        read_round(4'd10, "zero_r10", 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Random keys
        for (int n = 0; n < 3; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            start_and_wait(k, '0, -1, -1, 1'b0, $sformatf("rnd%0d", n));
        end

        // init re-pulsed during GEN is ignored
        k  = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        start_and_wait(k, k2, 3, 7, 1'b0, "ignore");

        // Reset in the middle of an expansion
        k = {$urandom, $urandom, $urandom, $urandom};
        key  = k;
        init = 1'b1;
        step();
        init = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_ready", ready, 1);
        check("midrst_kv", keyValid, 0);
        check("midrst_bsub", beforeSub, 0);
        for (int r = 0; r < 11; r++) exp_rk[r] = '0;
        check_schedule("midrst");
        k = {$urandom, $urandom, $urandom, $urandom};
        start_and_wait(k, '0, -1, -1, 1'b0, "after_rst");

        // init held high: back-to-back expansions, keyValid high for one cycle
        k  = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        start_and_wait(k, '0, -1, -1, 1'b1, "hold1");
        start_and_wait(k2, '0, -1, -1, 1'b1, "hold2");
        init = 1'b0;
        step();
        check("hold_idle_ready", ready, 1);
        check("hold_idle_kv", keyValid, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
